alu_dispatch: RTL and testbench

ALU_DISPATCH -- requirements
Module: alu_dispatch

---
 rtl/alu_dispatch.sv | 171 +++++++++++++++++
 tb/tb_alu_dispatch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// ALU dispatcher: accepts one decoded instruction class/funct request, issues
// the matching ALU opcode for one cycle and, for branches, resolves the branch
// from the ALU zero flag in the following cycle.
module alu_dispatch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       aluop,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic [2:0]       opc,
  output logic             op_valid,
  output logic             branch_valid,
  output logic             branch_taken,
  output logic             illegal,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  localparam logic [2:0] OPC_ADD = 3'b000;
  localparam logic [2:0] OPC_SUB = 3'b001;
  localparam logic [2:0] OPC_AND = 3'b010;
  localparam logic [2:0] OPC_OR  = 3'b011;
  localparam logic [2:0] OPC_XOR = 3'b100;
  localparam logic [2:0] OPC_SLT = 3'b101;

  localparam logic [1:0] CLS_LDST   = 2'b00;
  localparam logic [1:0] CLS_BRANCH = 2'b01;
  localparam logic [1:0] CLS_RTYPE  = 2'b10;

  state_t             state_q, state_d;
  logic [2:0]         opc_q, opc_d;
  logic [1:0]         aluop_q, aluop_d;
  logic [2:0]         funct3_q, funct3_d;
  logic               op_valid_q, op_valid_d;
  logic               branch_valid_q, branch_valid_d;
  logic               branch_taken_q, branch_taken_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;
  logic [3:0]         dec;

  // The N flag is observed by the ALU interface but no dispatch decision uses it.
  logic unused_alu_neg;
  assign unused_alu_neg = alu_neg;

  // Returns {illegal, opc} for one request.
  function automatic logic [3:0] decode(input logic [1:0] cls,
                                        input logic [2:0] f3,
                                        input logic       f7_5);
    logic [3:0] r;
    r = {1'b0, OPC_ADD};
    if (cls == CLS_LDST) begin
      r = {1'b0, OPC_ADD};
    end else if (cls == CLS_BRANCH) begin
      case (f3)
        3'b000, 3'b001: r = {1'b0, OPC_SUB};
        3'b100, 3'b101: r = {1'b0, OPC_SLT};
        default:        r = {1'b1, OPC_ADD};
      endcase
    end else begin
      case (f3)
        3'b000:  r = {1'b0, ((cls == CLS_RTYPE) && f7_5) ? OPC_SUB : OPC_ADD};
        3'b111:  r = {1'b0, OPC_AND};
        3'b110:  r = {1'b0, OPC_OR};
        3'b100:  r = {1'b0, OPC_XOR};
        3'b010:  r = {1'b0, OPC_SLT};
        default: r = {1'b1, OPC_ADD};
      endcase
    end
    return r;
  endfunction

  // BEQ/BGE take on a zero result, BNE/BLT on a non-zero result.
  function automatic logic resolve_taken(input logic [2:0] f3, input logic zero);
    logic t;
    case (f3)
      3'b000, 3'b101: t = zero;
      default:        t = ~zero;
    endcase
    return t;
  endfunction

  // Next-state, issue and resolve logic.
  always_comb begin
    state_d        = state_q;
    opc_d          = opc_q;
    aluop_d        = aluop_q;
    funct3_d       = funct3_q;
    op_valid_d     = 1'b0;
    branch_valid_d = 1'b0;
    branch_taken_d = 1'b0;
    illegal_d      = 1'b0;
    op_count_d     = op_count_q;
    dec            = decode(aluop, funct3, funct7_5);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (dec[3]) begin
            illegal_d = 1'b1;
          end else begin
            opc_d      = dec[2:0];
            aluop_d    = aluop;
            funct3_d   = funct3;
            op_valid_d = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (op_count_q != {CNT_W{1'b1}}) begin
          op_count_d = op_count_q + CNT_W'(1);
        end
        if (aluop_q == CLS_BRANCH) begin
          branch_valid_d = 1'b1;
          branch_taken_d = resolve_taken(funct3_q, alu_zero);
          state_d        = RESOLVE;
        end else begin
          state_d = IDLE;
        end
      end
      RESOLVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      opc_q          <= OPC_ADD;
      op_valid_q     <= 1'b0;
      branch_valid_q <= 1'b0;
      branch_taken_q <= 1'b0;
      illegal_q      <= 1'b0;
      op_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      opc_q          <= opc_d;
      op_valid_q     <= op_valid_d;
      branch_valid_q <= branch_valid_d;
      branch_taken_q <= branch_taken_d;
      illegal_q      <= illegal_d;
      op_count_q     <= op_count_d;
    end
  end

  // Captured request fields; only meaningful while an operation is in flight.
  always_ff @(posedge clk) begin
    aluop_q  <= aluop_d;
    funct3_q <= funct3_d;
  end

  assign in_ready     = (state_q == IDLE);
  assign opc          = opc_q;
  assign op_valid     = op_valid_q;
  assign branch_valid = branch_valid_q;
  assign branch_taken = branch_taken_q;
  assign illegal      = illegal_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: directed scenarios plus random requests compared
// against a table-driven model of the dispatch rules.
module tb_alu_dispatch;

  logic        clk, rst_n, in_valid, funct7_5, alu_zero, alu_neg;
  logic [1:0]  aluop;
  logic [2:0]  funct3;
  logic        in_ready, op_valid, branch_valid, branch_taken, illegal;
  logic [2:0]  opc;
  logic [15:0] op_count;
  logic        s_in_ready, s_op_valid, s_branch_valid, s_branch_taken, s_illegal;
  logic [2:0]  s_opc;
  logic [1:0]  s_op_count;

  int n_vec  = 0;
  int n_err  = 0;
  int exp_cnt = 0;
  logic [2:0] exp_opc = 3'b000;

  alu_dispatch #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct3(funct3), .funct7_5(funct7_5), .alu_zero(alu_zero),
    .alu_neg(alu_neg), .opc(opc), .op_valid(op_valid), .branch_valid(branch_valid),
    .branch_taken(branch_taken), .illegal(illegal), .op_count(op_count)
  );

  alu_dispatch #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .aluop(aluop), .funct3(funct3), .funct7_5(funct7_5), .alu_zero(alu_zero),
    .alu_neg(alu_neg), .opc(s_opc), .op_valid(s_op_valid), .branch_valid(s_branch_valid),
    .branch_taken(s_branch_taken), .illegal(s_illegal), .op_count(s_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: {legal, is_branch, opc} from the instruction-class tables.
  function automatic logic [4:0] ref_decode(input logic [1:0] a, input logic [2:0] f, input logic f7);
    if (a == 2'd0) return {1'b1, 1'b0, 3'd0};
    if (a == 2'd1) begin
      if (f == 3'd0 || f == 3'd1) return {1'b1, 1'b1, 3'd1};
      if (f == 3'd4 || f == 3'd5) return {1'b1, 1'b1, 3'd5};
      return 5'b0;
    end
    case (f)
      3'd0: return {1'b1, 1'b0, (a == 2'd2 && f7) ? 3'd1 : 3'd0};
      3'd7: return {1'b1, 1'b0, 3'd2};
      3'd6: return {1'b1, 1'b0, 3'd3};
      3'd4: return {1'b1, 1'b0, 3'd4};
      3'd2: return {1'b1, 1'b0, 3'd5};
      default: return 5'b0;
    endcase
  endfunction

  // Model: BEQ taken if equal, BNE if not equal, BLT if a<b (SLT result 1),
  // BGE if a>=b (SLT result 0).
  function automatic logic ref_taken(input logic [2:0] f, input logic z);
    case (f)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return !z;
      default: return z;
    endcase
  endfunction

  function automatic int sat3(input int c);
    return (c > 3) ? 3 : c;
  endfunction

  // One complete request, checked cycle by cycle.
  task automatic do_op(input logic [1:0] a, input logic [2:0] f, input logic f7, input logic z);
    logic [4:0] r;
    logic legal, br;
    r = ref_decode(a, f, f7);
    legal = r[4];
    br = r[3];
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rdy_before: got %b want 1", in_ready); end
    in_valid = 1'b1; aluop = a; funct3 = f; funct7_5 = f7; alu_zero = z;
    @(negedge clk);
    in_valid = 1'b0; aluop = 2'($urandom); funct3 = 3'($urandom); funct7_5 = 1'($urandom);
    if (!legal) begin
      n_vec++; if (illegal !== 1'b1) begin n_err++; $display("FAIL illegal_pulse a=%0d f=%0d: got %b want 1", a, f, illegal); end
      n_vec++; if (op_valid !== 1'b0 || branch_valid !== 1'b0) begin n_err++; $display("FAIL illegal_noissue: got ov=%b bv=%b want 0 0", op_valid, branch_valid); end
      n_vec++; if (opc !== exp_opc) begin n_err++; $display("FAIL illegal_opc: got %0d want %0d", opc, exp_opc); end
      n_vec++; if (op_count !== 16'(exp_cnt)) begin n_err++; $display("FAIL illegal_cnt: got %0d want %0d", op_count, exp_cnt); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL illegal_rdy: got %b want 1", in_ready); end
      @(negedge clk);
      n_vec++; if (illegal !== 1'b0) begin n_err++; $display("FAIL illegal_once: got %b want 0", illegal); end
    end else begin
      exp_opc = r[2:0];
      n_vec++; if (op_valid !== 1'b1 || illegal !== 1'b0) begin n_err++; $display("FAIL issue_valid a=%0d f=%0d: got ov=%b il=%b want 1 0", a, f, op_valid, illegal); end
      n_vec++; if (opc !== exp_opc) begin n_err++; $display("FAIL issue_opc a=%0d f=%0d f7=%b: got %0d want %0d", a, f, f7, opc, exp_opc); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL issue_busy: got %b want 0", in_ready); end
      if (exp_cnt < 65535) exp_cnt++;
      @(negedge clk);
      n_vec++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL op_valid_once: got %b want 0", op_valid); end
      n_vec++; if (opc !== exp_opc) begin n_err++; $display("FAIL opc_held: got %0d want %0d", opc, exp_opc); end
      n_vec++; if (op_count !== 16'(exp_cnt)) begin n_err++; $display("FAIL op_count: got %0d want %0d", op_count, exp_cnt); end
      n_vec++; if (s_op_count !== 2'(sat3(exp_cnt))) begin n_err++; $display("FAIL op_count_sat: got %0d want %0d", s_op_count, sat3(exp_cnt)); end
      if (br) begin
        n_vec++; if (branch_valid !== 1'b1) begin n_err++; $display("FAIL branch_valid: got %b want 1", branch_valid); end
        n_vec++; if (branch_taken !== ref_taken(f, z)) begin n_err++; $display("FAIL branch_taken f=%0d z=%b: got %b want %b", f, z, branch_taken, ref_taken(f, z)); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL resolve_busy: got %b want 0", in_ready); end
        @(negedge clk);
        n_vec++; if (branch_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL resolve_end: got bv=%b rdy=%b want 0 1", branch_valid, in_ready); end
      end else begin
        n_vec++; if (branch_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL nonbranch_end: got bv=%b rdy=%b want 0 1", branch_valid, in_ready); end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; aluop = 2'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    alu_zero = 1'b0; alu_neg = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if ({opc, op_valid, branch_valid, branch_taken, illegal} !== 7'b0) begin n_err++; $display("FAIL reset_outs: got opc=%0d ov=%b bv=%b bt=%b il=%b want all 0", opc, op_valid, branch_valid, branch_taken, illegal); end
    n_vec++; if (op_count !== 16'd0 || s_op_count !== 2'd0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0", op_count, s_op_count); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %b want 1", in_ready); end
    exp_cnt = 0; exp_opc = 3'd0;
  endtask

  task automatic test_directed;
    do_op(2'b10, 3'b000, 1'b1, 1'b0);   // SUB
    do_op(2'b01, 3'b001, 1'b0, 1'b0);   // BNE, not equal -> taken
    do_op(2'b01, 3'b101, 1'b0, 1'b1);   // BGE, zero -> taken
    do_op(2'b01, 3'b101, 1'b0, 1'b0);   // BGE, non-zero -> not taken
    do_op(2'b10, 3'b001, 1'b0, 1'b0);   // illegal R-type
    do_op(2'b11, 3'b000, 1'b1, 1'b0);   // ADDI ignores bit 30
    do_op(2'b00, 3'b111, 1'b1, 1'b0);   // load/store always ADD
    do_op(2'b01, 3'b010, 1'b0, 1'b0);   // illegal branch
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    in_valid = 1'b1; aluop = 2'b10; funct3 = 3'b111; funct7_5 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++; if (op_valid !== (i % 2 == 0)) begin n_err++; $display("FAIL b2b_alu cycle %0d: got %b want %b", i, op_valid, (i % 2 == 0)); end
      if (i % 2 == 0 && exp_cnt < 65535) exp_cnt++;
      if (i == 9) in_valid = 1'b0;
    end
    exp_opc = 3'd2;
    @(negedge clk);
    n_vec++; if (op_count !== 16'(exp_cnt) || opc !== exp_opc) begin n_err++; $display("FAIL b2b_alu_cnt: got %0d opc %0d want %0d opc %0d", op_count, opc, exp_cnt, exp_opc); end
    in_valid = 1'b1; aluop = 2'b01; funct3 = 3'b000; alu_zero = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_vec++; if (op_valid !== (i % 3 == 0) || branch_valid !== (i % 3 == 1)) begin n_err++; $display("FAIL b2b_br cycle %0d: got ov=%b bv=%b want %b %b", i, op_valid, branch_valid, (i % 3 == 0), (i % 3 == 1)); end
      if (i % 3 == 1) begin
        n_vec++; if (branch_taken !== 1'b1) begin n_err++; $display("FAIL b2b_br_taken: got %b want 1", branch_taken); end
      end
      if (i % 3 == 0 && exp_cnt < 65535) exp_cnt++;
      if (i == 8) in_valid = 1'b0;
    end
    exp_opc = 3'd1;
    @(negedge clk);
    n_vec++; if (op_count !== 16'(exp_cnt)) begin n_err++; $display("FAIL b2b_br_cnt: got %0d want %0d", op_count, exp_cnt); end
  endtask

  task automatic test_reset_in_resolve;
    @(negedge clk);
    in_valid = 1'b1; aluop = 2'b01; funct3 = 3'b000; alu_zero = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (branch_valid !== 1'b1) begin n_err++; $display("FAIL rr_pre_bv: got %b want 1", branch_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if ({opc, op_valid, branch_valid, branch_taken, illegal} !== 7'b0 || op_count !== 16'd0) begin n_err++; $display("FAIL rr_async: got opc=%0d ov=%b bv=%b bt=%b il=%b cnt=%0d want all 0", opc, op_valid, branch_valid, branch_taken, illegal, op_count); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0; exp_opc = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (branch_valid !== 1'b0 || illegal !== 1'b0 || in_ready !== 1'b1 || op_count !== 16'd0) begin n_err++; $display("FAIL rr_after %0d: got bv=%b il=%b rdy=%b cnt=%0d want 0 0 1 0", i, branch_valid, illegal, in_ready, op_count); end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 150; i++) begin
      alu_neg = 1'($urandom);
      do_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_in_resolve;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
